ipmask_seq: RTL

Sequential inner-product masking controller. It accepts one secret byte and a public vector L, pulls V-1 random bytes from the RNG over a valid/ready handshake, and produces V shares R satisfying S = ⊕ L[i]·R[i] with L[0] ≡ 1. It time-multiplexes a single gmul8 multiplier instead of instantiating V-1 of them. It sits between the key/secret source and the masked datapath, in front of the share-domain logic.

---
 rtl/ipmask_seq_if.sv | 34 +++
 rtl/ipmask_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ipmask_seq_if.sv
// rtl/ipmask_seq_if.sv - request, RNG and share-vector handshake bundle for ipmask_seq
//
// Parameter V : number of shares (>= 2).
// Signals:
//   in_valid/in_ready, S, L   secret request (S byte, public vector L, byte i at [8i+7:8i])
//   rnd_valid/rnd_ready, rnd  random byte stream from the RNG
//   out_valid/out_ready, R    share vector, R[i] at [8i+7:8i]
//   busy                      block is not idle
// Modports: slave = the masking block, master = the requester/RNG/consumer side.
interface ipmask_seq_if #(
    parameter int V = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     S;
    logic [V*8-1:0] L;
    logic           rnd_valid;
    logic           rnd_ready;
    logic [7:0]     rnd;
    logic           out_valid;
    logic           out_ready;
    logic [V*8-1:0] R;
    logic           busy;

    modport slave (
        input  in_valid, S, L, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, R, busy
    );

    modport master (
        output in_valid, S, L, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, R, busy
    );
endinterface

// File: rtl/ipmask_seq.sv
// rtl/ipmask_seq.sv - sequential inner-product masking controller with one shared GF(2^8) multiplier
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ipmask_seq_if.slave (request in, RNG bytes in, share vector out, busy)
// Parameter V : number of shares (>= 2).
// Optional feature macro: IPMASK_ZEROIZE_EN - when defined, R, acc and the
// latched L vector are cleared on the output handshake.
//
// Shares satisfy S = R[0] ^ XOR_{i>=1} L[i]*R[i] in GF(2^8), L[0] taken as 1.
module ipmask_seq #(
    parameter int V = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ipmask_seq_if.slave  bus
);
    localparam int             IW   = $clog2(V);
    localparam logic [IW-1:0]  LAST = IW'(V - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // GF(2^8) multiply, modulus x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    state_t            state;
    logic [7:0]        acc;
    logic [IW-1:0]     idx;
    logic [V-1:0][7:0] l_reg;
    logic [V-1:0][7:0] r_reg;
    logic              in_ready_q;
    logic              rnd_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [7:0]        prod;
    logic [7:0]        acc_next;

    // The single multiplier is shared across all share positions via idx
    assign prod     = gmul8(l_reg[idx], bus.rnd);
    assign acc_next = acc ^ prod;

    assign bus.in_ready  = in_ready_q;
    assign bus.rnd_ready = rnd_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.R         = r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= 8'h00;
            idx         <= '0;
            l_reg       <= '0;
            r_reg       <= '0;
            in_ready_q  <= 1'b1;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone completes the handshake
                    if (bus.in_valid) begin
                        l_reg       <= bus.L;
                        acc         <= bus.S;
                        idx         <= IW'(1);
                        state       <= COLLECT;
                        in_ready_q  <= 1'b0;
                        rnd_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.rnd_valid) begin
                        r_reg[idx] <= bus.rnd;
                        acc        <= acc_next;
                        if (idx == LAST) begin
                            // The last product closes the sum; idx stays at V-1
                            r_reg[0]    <= acc_next;
                            state       <= DONE;
                            rnd_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
`ifdef IPMASK_ZEROIZE_EN
                        r_reg       <= '0;
                        acc         <= 8'h00;
                        l_reg       <= '0;
`else
                        // Share material is left in place until the next request overwrites it
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    rnd_ready_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule
